reg_read_stage: RTL and testbench
=================================

Name: reg_read_stage

Overview:
Parametrised register-read pipeline stage between decode and execute.
- Per instruction, reads up to NUM_SRC source operands plus the current destination value from the flat register-file view.
- Tracks pending writes in a per-register scoreboard and forwards the writeback value in the same cycle.
- Holds results in an output pipeline register under a valid/ready handshake, so decode-side stall logic is replaced by backpressure.

Parameters:
XLEN, 64, operand/register width in bits
NUM_REGS, 16, architectural register count
REGW, 4, register index width (= clog2(NUM_REGS))
NUM_SRC, 2, source operand slots per instruction
PAYLOAD_W, 512, opaque decode sideband (rip, opcode, imm, disp, flags) passed through unchanged

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
flush  in  1  discard held instruction and clear scoreboard
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
in_src_reg  in  NUM_SRC*REGW  source register indices, slot i at [i*REGW +: REGW]
in_src_valid  in  NUM_SRC  per-slot source used
in_dest_reg  in  REGW  destination index
in_dest_valid  in  1  destination written by this instruction
in_payload  in  PAYLOAD_W  sideband
regfile_in  in  NUM_REGS*XLEN  current register file contents, reg r at [r*XLEN +: XLEN]
wb_valid  in  1  writeback commits this cycle
wb_reg  in  REGW  writeback index
wb_value  in  XLEN  writeback data (not yet visible in regfile_in)
out_valid  out  1  output register holds an instruction
out_ready  in  1  execute accepts
out_operand  out  NUM_SRC*XLEN  operand values
out_operand_valid  out  NUM_SRC  copies of in_src_valid
out_src_reg  out  NUM_SRC*REGW  copies of source indices
out_dest_reg  out  REGW  destination index
out_dest_valid  out  1  destination used
out_dest_value  out  XLEN  pre-instruction destination value
out_payload  out  PAYLOAD_W  sideband
busy_out  out  NUM_REGS  scoreboard bits, for debug/verification

Behaviour:
- Reset: out_valid=0, busy=0, all out_* data registers=0; in_ready is combinational and equals 0 while reset=1.
- Read set: every slot with in_src_valid=1, plus the destination register when in_dest_valid=1.
- Ready: slot_free = !out_valid || out_ready.
- Hazard: a register in the read set is hazardous when busy[r]=1 and !(wb_valid && wb_reg==r).
- in_ready = slot_free && !hazard && !flush && !reset.
- Accept: accept = in_valid && in_ready. On accept, next-edge out_valid=1 and all out_* are loaded. Latency is exactly 1 cycle from accept to out_valid.
- Operand select, per read: if wb_valid && wb_reg==r, use wb_value (bypass); otherwise use regfile_in[r]. Unused slots load 0.
- Hold: when out_valid && !out_ready, all out_* are held stable and in_ready=0.
- Drain: out_ready && out_valid && !accept drives out_valid to 0 at the next edge. Back-to-back accept gives one instruction per cycle.
- Scoreboard set: on accept with in_dest_valid=1, busy[in_dest_reg] becomes 1.
- Scoreboard clear: wb_valid clears busy[wb_reg].
- Same register set and cleared in the same cycle: set wins, because the new producer is the youngest.
- WAW: a busy destination stalls exactly like a busy source, so at most one producer is in flight per register.
- Flush: next edge gives out_valid=0 and busy=0. No accept happens in the flush cycle. wb in the flush cycle is ignored by the scoreboard.
- Reset mid-handshake: the held instruction is dropped with no partial state.
- Valid/payload stability: out_valid never drops without out_ready or flush/reset.

Test Plan:
- Reset, then regfile r3=0x11, r5=0x22; accept src(3,5) with dest 7. Next cycle: out_valid=1, operands 0x11/0x22, busy_out=0x0080.
- Dependent issue: after the above, present src0=7. Required: in_ready=0 each cycle until wb_valid, wb_reg=7, wb_value=0xABCD; in that same cycle in_ready=1, and out_operand slot0=0xABCD next cycle. busy[7] clears, or stays 1 if the new instruction also writes r7.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1. Required: out_* stable, in_ready=0 throughout; release gives 1 transfer per cycle with no loss or duplication over 8 instructions.
- Simultaneous set/clear: busy[2]=1. In one cycle, wb to r2 and accept an instruction with dest 2 and no sources. Required: busy[2]=1 afterwards.
- Flush with out_valid=1 and busy=0x00F0. Required: next cycle out_valid=0, busy_out=0, and an instruction presented during flush is not accepted.
- Unused slots and random stress: in_src_valid=2'b00 gives operands=0 and valid bits=0. Then run 1000 random cycles against a reference scoreboard model: no operand read from a busy register without bypass.

Source files
------------

// File: rtl/reg_read_stage.sv
// Register-read stage between decode and execute: reads operands with writeback bypass,
// tracks in-flight writes in a scoreboard, and buffers one instruction under valid/ready.
module reg_read_stage #(
    parameter int XLEN      = 64,
    parameter int NUM_REGS  = 16,
    parameter int REGW      = 4,
    parameter int NUM_SRC   = 2,
    parameter int PAYLOAD_W = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*REGW-1:0]  in_src_reg,
    input  logic [NUM_SRC-1:0]       in_src_valid,
    input  logic [REGW-1:0]          in_dest_reg,
    input  logic                     in_dest_valid,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic [NUM_REGS*XLEN-1:0] regfile_in,
    input  logic                     wb_valid,
    input  logic [REGW-1:0]          wb_reg,
    input  logic [XLEN-1:0]          wb_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_SRC*XLEN-1:0]  out_operand,
    output logic [NUM_SRC-1:0]       out_operand_valid,
    output logic [NUM_SRC*REGW-1:0]  out_src_reg,
    output logic [REGW-1:0]          out_dest_reg,
    output logic                     out_dest_valid,
    output logic [XLEN-1:0]          out_dest_value,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [NUM_REGS-1:0]      busy_out
);

    logic [XLEN-1:0]         regs [NUM_REGS];
    logic [REGW-1:0]         srcIdx [NUM_SRC];
    logic [NUM_REGS-1:0]     busy;
    logic [NUM_REGS-1:0]     busyNext;
    logic [NUM_SRC*XLEN-1:0] operandNext;
    logic [XLEN-1:0]         destValueNext;
    logic                    slotFree;
    logic                    hazard;
    logic                    accept;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_regs
        assign regs[r] = regfile_in[r*XLEN +: XLEN];
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign srcIdx[s] = in_src_reg[s*REGW +: REGW];
    end

    // A register being written back this cycle is read from the bypass and is never a hazard.
    always_comb begin
        hazard        = 1'b0;
        operandNext   = '0;
        destValueNext = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_src_valid[i]) begin
                if (wb_valid && wb_reg == srcIdx[i]) begin
                    operandNext[i*XLEN +: XLEN] = wb_value;
                end else begin
                    operandNext[i*XLEN +: XLEN] = regs[srcIdx[i]];
                    if (busy[srcIdx[i]]) hazard = 1'b1;
                end
            end
        end
        if (in_dest_valid) begin
            if (wb_valid && wb_reg == in_dest_reg) begin
                destValueNext = wb_value;
            end else begin
                destValueNext = regs[in_dest_reg];
                if (busy[in_dest_reg]) hazard = 1'b1;
            end
        end
    end

    assign slotFree = !out_valid || out_ready;
    assign in_ready = slotFree && !hazard && !flush && !reset;
    assign accept   = in_valid && in_ready;
    assign busy_out = busy;

    // Set after clear: a new producer of the register being retired is the youngest one.
    always_comb begin
        busyNext = busy;
        if (wb_valid) busyNext[wb_reg] = 1'b0;
        if (accept && in_dest_valid) busyNext[in_dest_reg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid         <= 1'b0;
            busy              <= '0;
            out_operand       <= '0;
            out_operand_valid <= '0;
            out_src_reg       <= '0;
            out_dest_reg      <= '0;
            out_dest_valid    <= 1'b0;
            out_dest_value    <= '0;
            out_payload       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            busy      <= '0;
        end else begin
            busy <= busyNext;
            if (accept) begin
                out_valid         <= 1'b1;
                out_operand       <= operandNext;
                out_operand_valid <= in_src_valid;
                out_src_reg       <= in_src_reg;
                out_dest_reg      <= in_dest_reg;
                out_dest_valid    <= in_dest_valid;
                out_dest_value    <= destValueNext;
                out_payload       <= in_payload;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios plus a randomized run
// against a producer-set reference model.
module tb_reg_read_stage;

    localparam int XLEN      = 64;
    localparam int NUM_REGS  = 16;
    localparam int REGW      = 4;
    localparam int NUM_SRC   = 2;
    localparam int PAYLOAD_W = 512;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_SRC*REGW-1:0]  in_src_reg;
    logic [NUM_SRC-1:0]       in_src_valid;
    logic [REGW-1:0]          in_dest_reg;
    logic                     in_dest_valid;
    logic [PAYLOAD_W-1:0]     in_payload;
    wire  [NUM_REGS*XLEN-1:0] regfile_in;
    logic                     wb_valid;
    logic [REGW-1:0]          wb_reg;
    logic [XLEN-1:0]          wb_value;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_SRC*XLEN-1:0]  out_operand;
    logic [NUM_SRC-1:0]       out_operand_valid;
    logic [NUM_SRC*REGW-1:0]  out_src_reg;
    logic [REGW-1:0]          out_dest_reg;
    logic                     out_dest_valid;
    logic [XLEN-1:0]          out_dest_value;
    logic [PAYLOAD_W-1:0]     out_payload;
    logic [NUM_REGS-1:0]      busy_out;

    logic [XLEN-1:0] regs [NUM_REGS];
    int checks;
    int passes;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regfile_in[g*XLEN +: XLEN] = regs[g];
    end

    reg_read_stage #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .REGW(REGW), .NUM_SRC(NUM_SRC), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_reg(in_src_reg), .in_src_valid(in_src_valid),
        .in_dest_reg(in_dest_reg), .in_dest_valid(in_dest_valid),
        .in_payload(in_payload), .regfile_in(regfile_in),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_value(wb_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operand(out_operand), .out_operand_valid(out_operand_valid),
        .out_src_reg(out_src_reg), .out_dest_reg(out_dest_reg),
        .out_dest_valid(out_dest_valid), .out_dest_value(out_dest_value),
        .out_payload(out_payload), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_src_reg    = '0;
        in_src_valid  = '0;
        in_dest_reg   = '0;
        in_dest_valid = 1'b0;
        in_payload    = '0;
        wb_valid      = 1'b0;
        wb_reg        = '0;
        wb_value      = '0;
        out_ready     = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        in_valid = 1'b1; in_src_valid = 2'b11; in_dest_valid = 1'b1; in_dest_reg = 4'd4;
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); else passes++;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (busy_out !== 16'h0) $display("[TB] FAIL reset_busy got %h want 0000", busy_out); else passes++;
        checks++; if (out_operand !== '0) $display("[TB] FAIL reset_operand got %h want 0", out_operand); else passes++;
        checks++; if (out_payload !== '0 || out_dest_value !== '0) $display("[TB] FAIL reset_data got %h/%h want 0/0", out_payload, out_dest_value); else passes++;
        reset = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        logic [PAYLOAD_W-1:0] pay;
        pay = {16{$urandom}};
        idle();
        regs[3] = 64'h11; regs[5] = 64'h22; regs[7] = 64'h5555;
        in_valid = 1'b1; in_src_reg = {4'd5, 4'd3}; in_src_valid = 2'b11;
        in_dest_reg = 4'd7; in_dest_valid = 1'b1; in_payload = pay;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL basic_in_ready got %b want 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL basic_out_valid got %b want 1", out_valid); else passes++;
        checks++; if (out_operand !== {64'h22, 64'h11}) $display("[TB] FAIL basic_operand got %h want %h", out_operand, {64'h22, 64'h11}); else passes++;
        checks++; if (busy_out !== 16'h0080) $display("[TB] FAIL basic_busy got %h want 0080", busy_out); else passes++;
        checks++; if (out_dest_value !== 64'h5555 || out_dest_reg !== 4'd7) $display("[TB] FAIL basic_dest got %h/%0d want 5555/7", out_dest_value, out_dest_reg); else passes++;
        checks++; if (out_payload !== pay) $display("[TB] FAIL basic_payload got %h want %h", out_payload, pay); else passes++;
    endtask

    task automatic test_dependent();
        idle();
        in_valid = 1'b1; in_src_reg = {4'd0, 4'd7}; in_src_valid = 2'b01;
        in_dest_reg = 4'd7; in_dest_valid = 1'b1; in_payload = PAYLOAD_W'(99);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("[TB] FAIL dep_stall cycle %0d got %b want 0", c, in_ready); else passes++;
            tick();
        end
        wb_valid = 1'b1; wb_reg = 4'd7; wb_value = 64'hABCD;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL dep_release got %b want 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b1 || out_operand[XLEN-1:0] !== 64'hABCD) $display("[TB] FAIL dep_bypass got %b/%h want 1/abcd", out_valid, out_operand[XLEN-1:0]); else passes++;
        checks++; if (out_dest_value !== 64'hABCD) $display("[TB] FAIL dep_dest_bypass got %h want abcd", out_dest_value); else passes++;
        checks++; if (busy_out !== 16'h0080) $display("[TB] FAIL dep_busy_rewrite got %h want 0080", busy_out); else passes++;
        idle();
        wb_valid = 1'b1; wb_reg = 4'd7; wb_value = 64'h1234;
        tick();
        checks++; if (busy_out !== 16'h0 || out_valid !== 1'b0) $display("[TB] FAIL dep_retire got %h/%b want 0000/0", busy_out, out_valid); else passes++;
        idle();
    endtask

    task automatic test_backpressure();
        logic [NUM_SRC*XLEN-1:0] expOp [8];
        logic [NUM_SRC*REGW-1:0] srcs [8];
        int recv[$];
        idle();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            srcs[k]  = NUM_SRC*REGW'($urandom);
            expOp[k] = {regs[srcs[k][REGW +: REGW]], regs[srcs[k][0 +: REGW]]};
        end
        in_valid = 1'b1; in_src_valid = 2'b11; in_src_reg = srcs[0]; in_payload = PAYLOAD_W'(0);
        tick();
        in_src_reg = srcs[1]; in_payload = PAYLOAD_W'(1);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_hold_ready cycle %0d got %b want 0", c, in_ready); else passes++;
            checks++; if (out_valid !== 1'b1 || out_payload !== PAYLOAD_W'(0)) $display("[TB] FAIL bp_hold_payload cycle %0d got %b/%h want 1/0", c, out_valid, out_payload[7:0]); else passes++;
            checks++; if (out_operand !== expOp[0]) $display("[TB] FAIL bp_hold_operand cycle %0d got %h want %h", c, out_operand, expOp[0]); else passes++;
            tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            in_src_reg = srcs[k]; in_payload = PAYLOAD_W'(k);
            #1;
            checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_stream_ready item %0d got %b want 1", k, in_ready); else passes++;
            if (out_valid && out_ready) recv.push_back(int'(out_payload[7:0]));
            tick();
            checks++; if (out_operand !== expOp[k]) $display("[TB] FAIL bp_stream_operand item %0d got %h want %h", k, out_operand, expOp[k]); else passes++;
        end
        in_valid = 1'b0;
        #1;
        if (out_valid && out_ready) recv.push_back(int'(out_payload[7:0]));
        tick();
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain got %b want 0", out_valid); else passes++;
        checks++; if (recv.size() != 8) $display("[TB] FAIL bp_count got %0d want 8", recv.size()); else passes++;
        for (int k = 0; k < recv.size() && k < 8; k++) begin
            checks++; if (recv[k] != k) $display("[TB] FAIL bp_order slot %0d got %0d want %0d", k, recv[k], k); else passes++;
        end
        idle();
    endtask

    task automatic test_set_clear();
        idle();
        in_valid = 1'b1; in_dest_valid = 1'b1; in_dest_reg = 4'd2;
        tick();
        checks++; if (busy_out !== 16'h0004) $display("[TB] FAIL sc_setup got %h want 0004", busy_out); else passes++;
        wb_valid = 1'b1; wb_reg = 4'd2; wb_value = 64'h77;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL sc_ready got %b want 1", in_ready); else passes++;
        tick();
        checks++; if (busy_out !== 16'h0004) $display("[TB] FAIL sc_set_wins got %h want 0004", busy_out); else passes++;
        idle();
        wb_valid = 1'b1; wb_reg = 4'd2;
        tick();
        checks++; if (busy_out !== 16'h0) $display("[TB] FAIL sc_retire got %h want 0000", busy_out); else passes++;
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int d = 4; d < 8; d++) begin
            in_valid = 1'b1; in_dest_valid = 1'b1; in_dest_reg = REGW'(d);
            tick();
        end
        checks++; if (out_valid !== 1'b1 || busy_out !== 16'h00F0) $display("[TB] FAIL flush_setup got %b/%h want 1/00f0", out_valid, busy_out); else passes++;
        flush = 1'b1; in_dest_reg = 4'd1; wb_valid = 1'b1; wb_reg = 4'd4;
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0 || busy_out !== 16'h0) $display("[TB] FAIL flush_clear got %b/%h want 0/0000", out_valid, busy_out); else passes++;
        idle();
    endtask

    task automatic test_unused();
        idle();
        in_valid = 1'b1; in_src_reg = 8'hA5; in_src_valid = 2'b00; in_dest_reg = 4'd3;
        tick();
        checks++; if (out_valid !== 1'b1 || out_operand !== '0) $display("[TB] FAIL unused_operand got %b/%h want 1/0", out_valid, out_operand); else passes++;
        checks++; if (out_operand_valid !== 2'b00 || out_dest_valid !== 1'b0 || out_dest_value !== '0) $display("[TB] FAIL unused_valid got %b/%b/%h want 00/0/0", out_operand_valid, out_dest_valid, out_dest_value); else passes++;
        checks++; if (out_src_reg !== 8'hA5) $display("[TB] FAIL unused_src_copy got %h want a5", out_src_reg); else passes++;
        idle();
        tick();
    endtask

    task automatic test_random();
        bit pending [int];
        int busyList[$];
        bit mValid;
        bit expReady;
        logic [NUM_SRC*XLEN-1:0] mOp;
        logic [NUM_SRC-1:0] mOpV;
        logic [NUM_SRC*REGW-1:0] mSrc;
        logic [REGW-1:0] mDest;
        logic mDestV;
        logic [XLEN-1:0] mDestVal;
        logic [PAYLOAD_W-1:0] mPay;
        logic [NUM_REGS-1:0] expBusy;
        logic [REGW-1:0] r;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mValid = 1'b0; mOp = '0; mOpV = '0; mSrc = '0; mDest = '0; mDestV = 1'b0; mDestVal = '0; mPay = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int q = 0; q < NUM_REGS; q++) if ($urandom_range(0, 7) == 0) regs[q] = {$urandom, $urandom};
            in_valid      = ($urandom_range(0, 9) < 7);
            in_src_reg    = NUM_SRC*REGW'($urandom);
            in_src_valid  = NUM_SRC'($urandom);
            in_dest_reg   = REGW'($urandom);
            in_dest_valid = 1'($urandom);
            in_payload    = {16{$urandom}};
            out_ready     = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 49) == 0);
            busyList.delete();
            foreach (pending[k]) busyList.push_back(k);
            wb_value = {$urandom, $urandom};
            wb_reg   = REGW'($urandom);
            wb_valid = 1'b0;
            if (busyList.size() > 0 && $urandom_range(0, 1) == 1) begin
                wb_valid = 1'b1;
                wb_reg   = REGW'(busyList[$urandom_range(0, busyList.size() - 1)]);
            end
            #1;
            // An instruction may go only if every register it reads has no producer still in flight.
            expReady = (!mValid || out_ready) && !flush;
            for (int i = 0; i < NUM_SRC; i++) begin
                r = in_src_reg[i*REGW +: REGW];
                if (in_src_valid[i] && pending.exists(int'(r)) && !(wb_valid && wb_reg == r)) expReady = 1'b0;
            end
            if (in_dest_valid && pending.exists(int'(in_dest_reg)) && !(wb_valid && wb_reg == in_dest_reg)) expReady = 1'b0;
            checks++; if (in_ready !== expReady) $display("[TB] FAIL rnd_in_ready cycle %0d got %b want %b", cyc, in_ready, expReady); else passes++;
            if (flush) begin
                mValid = 1'b0;
                pending.delete();
            end else begin
                if (wb_valid) pending.delete(int'(wb_reg));
                if (in_valid && expReady) begin
                    mValid = 1'b1;
                    mOp = '0;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        r = in_src_reg[i*REGW +: REGW];
                        if (in_src_valid[i]) mOp[i*XLEN +: XLEN] = (wb_valid && wb_reg == r) ? wb_value : regs[r];
                    end
                    mDestVal = '0;
                    if (in_dest_valid) mDestVal = (wb_valid && wb_reg == in_dest_reg) ? wb_value : regs[in_dest_reg];
                    mOpV = in_src_valid; mSrc = in_src_reg; mDest = in_dest_reg; mDestV = in_dest_valid; mPay = in_payload;
                    if (in_dest_valid) pending[int'(in_dest_reg)] = 1'b1;
                end else if (out_ready) begin
                    mValid = 1'b0;
                end
            end
            expBusy = '0;
            foreach (pending[k]) expBusy[k] = 1'b1;
            tick();
            checks++; if (out_valid !== mValid) $display("[TB] FAIL rnd_out_valid cycle %0d got %b want %b", cyc, out_valid, mValid); else passes++;
            checks++; if (busy_out !== expBusy) $display("[TB] FAIL rnd_busy cycle %0d got %h want %h", cyc, busy_out, expBusy); else passes++;
            if (mValid) begin
                checks++; if (out_operand !== mOp || out_dest_value !== mDestVal) $display("[TB] FAIL rnd_data cycle %0d got %h/%h want %h/%h", cyc, out_operand, out_dest_value, mOp, mDestVal); else passes++;
                checks++; if ({out_operand_valid, out_src_reg, out_dest_reg, out_dest_valid} !== {mOpV, mSrc, mDest, mDestV}) $display("[TB] FAIL rnd_meta cycle %0d got %h want %h", cyc, {out_operand_valid, out_src_reg, out_dest_reg, out_dest_valid}, {mOpV, mSrc, mDest, mDestV}); else passes++;
                checks++; if (out_payload !== mPay) $display("[TB] FAIL rnd_payload cycle %0d got %h want %h", cyc, out_payload, mPay); else passes++;
            end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        passes = 0;
        for (int q = 0; q < NUM_REGS; q++) regs[q] = {$urandom, $urandom};
        idle();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_dependent();
        test_backpressure();
        test_set_clear();
        test_flush();
        test_unused();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule
